// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: two-master round-robin arbiter in front of a single
// read-only slave port, with a per-transaction watchdog.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   m0_addr_i / m1_addr_i   master word address
//   m0_stb_i  / m1_stb_i    master request
//   m0_data_o / m1_data_o   master read data (held until next completion)
//   m0_ack_o  / m1_ack_o    one-cycle completion pulse
//   m0_err_o  / m1_err_o    one-cycle watchdog timeout pulse
//   s_addr_o, s_stb_o       slave request (held for the whole transaction)
//   s_data_i, s_ack_i       slave response
module rom_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:2] m0_addr_i,
    input  logic                  m0_stb_i,
    output logic [31:0]           m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:2] m1_addr_i,
    input  logic                  m1_stb_i,
    output logic [31:0]           m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:2] s_addr_o,
    output logic                  s_stb_o,
    input  logic [31:0]           s_data_i,
    input  logic                  s_ack_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WDOG_W = 8;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    owner_q;
    logic                    owner_d;
    logic                    last_q;
    logic                    last_d;
    logic [WDOG_W-1:0]       wdog_q;
    logic [WDOG_W-1:0]       wdog_d;
    logic [ADDR_WIDTH-1:2]   addr_d;
    logic                    stb_d;
    logic [DATA_W-1:0]       data0_d;
    logic [DATA_W-1:0]       data1_d;
    logic                    ack0_d;
    logic                    ack1_d;
    logic                    err0_d;
    logic                    err1_d;
    logic                    elig0;
    logic                    elig1;
    logic                    grant;

    // State and all output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            wdog_q    <= '0;
            s_addr_o  <= '0;
            s_stb_o   <= 1'b0;
            m0_data_o <= '0;
            m1_data_o <= '0;
            m0_ack_o  <= 1'b0;
            m1_ack_o  <= 1'b0;
            m0_err_o  <= 1'b0;
            m1_err_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            s_addr_o  <= addr_d;
            s_stb_o   <= stb_d;
            m0_data_o <= data0_d;
            m1_data_o <= data1_d;
            m0_ack_o  <= ack0_d;
            m1_ack_o  <= ack1_d;
            m0_err_o  <= err0_d;
            m1_err_o  <= err1_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        addr_d  = s_addr_o;
        stb_d   = s_stb_o;
        data0_d = m0_data_o;
        data1_d = m1_data_o;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        grant   = 1'b0;

        // A master still seeing its own ack/err pulse is not re-granted yet
        elig0 = m0_stb_i & ~m0_ack_o & ~m0_err_o;
        elig1 = m1_stb_i & ~m1_ack_o & ~m1_err_o;

        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    // Tie goes to the master that did not win last time
                    grant   = (elig0 & elig1) ? ~last_q : elig1;
                    state_d = ST_BUSY;
                    owner_d = grant;
                    last_d  = grant;
                    addr_d  = grant ? m1_addr_i : m0_addr_i;
                    stb_d   = 1'b1;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                if (s_ack_i) begin
                    // Data is always captured; ack only if the owner still asks
                    if (owner_q) begin
                        data1_d = s_data_i;
                        ack1_d  = m1_stb_i;
                    end else begin
                        data0_d = s_data_i;
                        ack0_d  = m0_stb_i;
                    end
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    if (owner_q) begin
                        err1_d = 1'b1;
                    end else begin
                        err0_d = 1'b1;
                    end
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios followed by a randomized
// phase, every cycle compared against a transaction-level reference model.
module tb_rom_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned WA = AW - 2;
    localparam int unsigned TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:2] m0_addr_i;
    logic          m0_stb_i;
    logic [31:0]   m0_data_o;
    logic          m0_ack_o;
    logic          m0_err_o;
    logic [AW-1:2] m1_addr_i;
    logic          m1_stb_i;
    logic [31:0]   m1_data_o;
    logic          m1_ack_o;
    logic          m1_err_o;
    logic [AW-1:2] s_addr_o;
    logic          s_stb_o;
    logic [31:0]   s_data_i;
    logic          s_ack_i;

    rom_port_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m0_addr_i (m0_addr_i),
        .m0_stb_i  (m0_stb_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_addr_i (m1_addr_i),
        .m1_stb_i  (m1_stb_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_addr_o  (s_addr_o),
        .s_stb_o   (s_stb_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: one outstanding transaction described by who owns it
    // and the edge count at which it was granted.
    logic [31:0]   e_data [2];
    bit            e_ack  [2];
    bit            e_err  [2];
    bit            e_stb;
    logic [AW-1:2] e_addr;
    bit            busy;
    int            who;
    int            last_won;
    int            t0;
    int            cyc = 0;

    bit            auto_slave = 1'b0;
    int            stb_age = 0;
    int            ngrants;
    int            k;
    logic          prev_stb;
    logic [31:0]   d_before;
    logic [AW-1:2] want_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        bit stb [2];
        bit old_ack [2];
        bit old_err [2];
        bit want0;
        bit want1;
        int nwho;
        cyc++;
        if (rst_i) begin
            e_data   = '{32'h0, 32'h0};
            e_ack    = '{1'b0, 1'b0};
            e_err    = '{1'b0, 1'b0};
            e_stb    = 1'b0;
            e_addr   = '0;
            busy     = 1'b0;
            last_won = 1;
            return;
        end
        old_ack = e_ack;
        old_err = e_err;
        e_ack   = '{1'b0, 1'b0};
        e_err   = '{1'b0, 1'b0};
        stb[0]  = m0_stb_i;
        stb[1]  = m1_stb_i;
        if (busy) begin
            if (s_ack_i) begin
                e_data[who] = s_data_i;
                e_ack[who]  = stb[who];
                busy        = 1'b0;
                e_stb       = 1'b0;
            end else if (cyc - t0 >= TO) begin
                e_err[who] = 1'b1;
                busy       = 1'b0;
                e_stb      = 1'b0;
            end
        end else begin
            want0 = stb[0] && !old_ack[0] && !old_err[0];
            want1 = stb[1] && !old_ack[1] && !old_err[1];
            if (want0 || want1) begin
                nwho     = (want0 && want1) ? (1 - last_won) : (want1 ? 1 : 0);
                busy     = 1'b1;
                who      = nwho;
                last_won = nwho;
                t0       = cyc;
                e_stb    = 1'b1;
                e_addr   = (nwho == 1) ? m1_addr_i : m0_addr_i;
            end
        end
    endtask

    // One clock: update model, let the edge pass, compare every output
    task automatic step();
        model_edge();
        @(posedge clk_i);
        #1;
        chk("m0_data", 64'(m0_data_o), 64'(e_data[0]));
        chk("m1_data", 64'(m1_data_o), 64'(e_data[1]));
        chk("m0_ack",  64'(m0_ack_o),  64'(e_ack[0]));
        chk("m1_ack",  64'(m1_ack_o),  64'(e_ack[1]));
        chk("m0_err",  64'(m0_err_o),  64'(e_err[0]));
        chk("m1_err",  64'(m1_err_o),  64'(e_err[1]));
        chk("s_stb",   64'(s_stb_o),   64'(e_stb));
        chk("s_addr",  64'(s_addr_o),  64'(e_addr));
        chk("resp_excl", 64'((32'(m0_ack_o) + 32'(m1_ack_o) + 32'(m0_err_o) + 32'(m1_err_o)) <= 1), 64'(1));
        stb_age = s_stb_o ? stb_age + 1 : 0;
        if (auto_slave) begin
            s_ack_i  = (stb_age == 2);
            s_data_i = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        m0_addr_i = '0;
        m0_stb_i  = 1'b0;
        m1_addr_i = '0;
        m1_stb_i  = 1'b0;
        s_data_i  = '0;
        s_ack_i   = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        chk("rst_stb",   64'(s_stb_o),   64'(0));
        chk("rst_addr",  64'(s_addr_o),  64'(0));
        chk("rst_data0", 64'(m0_data_o), 64'(0));

        // Single master read with a one-cycle slave
        m0_addr_i = WA'(16'h010);
        m0_stb_i  = 1'b1;
        step();
        chk("single_addr", 64'(s_addr_o), 64'(16'h010));
        chk("single_stb",  64'(s_stb_o),  64'(1));
        step();
        chk("single_noack_early", 64'(m0_ack_o), 64'(0));
        s_ack_i  = 1'b1;
        s_data_i = 32'hDEADBEEF;
        step();
        chk("single_ack",  64'(m0_ack_o),  64'(1));
        chk("single_data", 64'(m0_data_o), 64'(32'hDEADBEEF));
        chk("single_m1",   64'(m1_ack_o),  64'(0));
        s_ack_i  = 1'b0;
        m0_stb_i = 1'b0;
        step();
        chk("single_pulse", 64'(m0_ack_o),  64'(0));
        chk("single_hold",  64'(m0_data_o), 64'(32'hDEADBEEF));

        // Tie after reset: alternating grants starting with master0
        do_reset();
        m0_addr_i  = WA'(16'h004);
        m1_addr_i  = WA'(16'h008);
        m0_stb_i   = 1'b1;
        m1_stb_i   = 1'b1;
        auto_slave = 1'b1;
        ngrants    = 0;
        prev_stb   = s_stb_o;
        for (int i = 0; i < 13; i++) begin
            step();
            if (s_stb_o && !prev_stb) begin
                want_addr = (ngrants % 2 == 0) ? WA'(16'h004) : WA'(16'h008);
                chk("tie_order", 64'(s_addr_o), 64'(want_addr));
                ngrants++;
            end
            prev_stb = s_stb_o;
        end
        chk("tie_grants", 64'(ngrants >= 4), 64'(1));
        m0_stb_i = 1'b0;
        m1_stb_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        auto_slave = 1'b0;
        s_ack_i    = 1'b0;

        // Watchdog timeout on master1
        do_reset();
        d_before  = m1_data_o;
        m1_addr_i = WA'(16'h055);
        m1_stb_i  = 1'b1;
        step();
        chk("to_start", 64'(s_stb_o), 64'(1));
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            k++;
            if (m1_err_o) break;
        end
        chk("to_latency", 64'(k), 64'(TO));
        chk("to_data",    64'(m1_data_o), 64'(d_before));
        chk("to_stb",     64'(s_stb_o),   64'(0));
        step();
        chk("to_pulse", 64'(m1_err_o), 64'(0));
        step();
        chk("to_regrant", 64'(s_stb_o), 64'(1));
        s_ack_i  = 1'b1;
        s_data_i = 32'hA5A5_0001;
        step();
        chk("to_next_ack", 64'(m1_ack_o), 64'(1));
        s_ack_i  = 1'b0;
        m1_stb_i = 1'b0;
        step();

        // Master0 abandons its request before the slave answers
        m0_addr_i = WA'(16'h020);
        m0_stb_i  = 1'b1;
        step();
        m0_stb_i = 1'b0;
        step();
        s_ack_i  = 1'b1;
        s_data_i = 32'h12345678;
        step();
        chk("abort_noack", 64'(m0_ack_o),  64'(0));
        chk("abort_data",  64'(m0_data_o), 64'(32'h12345678));
        s_ack_i = 1'b0;
        step();
        chk("abort_idle", 64'(s_stb_o), 64'(0));

        // Reset while master1 is in flight, late slave ack ignored
        m1_addr_i = WA'(16'h033);
        m1_stb_i  = 1'b1;
        step();
        chk("rmid_busy", 64'(s_stb_o), 64'(1));
        rst_i = 1'b1;
        step();
        chk("rmid_stb",  64'(s_stb_o),   64'(0));
        chk("rmid_data", 64'(m1_data_o), 64'(0));
        rst_i    = 1'b0;
        m1_stb_i = 1'b0;
        s_ack_i  = 1'b1;
        s_data_i = 32'hFFFF_FFFF;
        step();
        chk("rmid_noack", 64'(m1_ack_o), 64'(0));
        chk("rmid_noerr", 64'(m1_err_o), 64'(0));
        s_ack_i   = 1'b0;
        m0_addr_i = WA'(16'h004);
        m1_addr_i = WA'(16'h008);
        m0_stb_i  = 1'b1;
        m1_stb_i  = 1'b1;
        step();
        chk("rmid_m0_first", 64'(s_addr_o), 64'(16'h004));
        m0_stb_i = 1'b0;
        m1_stb_i = 1'b0;
        s_ack_i  = 1'b1;
        step();
        s_ack_i = 1'b0;
        step();

        // Randomized traffic, slave latency and resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) m0_stb_i = ~m0_stb_i;
            if ($urandom_range(0, 3) == 0) m1_stb_i = ~m1_stb_i;
            m0_addr_i = WA'($urandom);
            m1_addr_i = WA'($urandom);
            s_ack_i   = ($urandom_range(0, 2) == 0);
            s_data_i  = $urandom;
            rst_i     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
